// File: rtl/rom_burst_reader.sv
// rom_burst_reader
//
// Read initiator for a synchronous ROM (en/address in, data out one cycle
// later). A start command latches base_addr/len and fetches len consecutive
// words (address wraps modulo 2^ADDR_W). The words go out on a valid/ready
// stream with full backpressure. A 3-entry FIFO absorbs returning data. Reads
// are credit-limited so that buffered plus in-flight words never exceed 3.
//
// Ports:
//   clk        clock, all logic on posedge
//   rst        synchronous active-high reset
//   start      burst request, accepted only while busy=0
//   base_addr  first ROM address of the burst (sampled with start)
//   len        number of words, 0..2^(ADDR_W+1)-1 (sampled with start)
//   busy       burst in progress
//   done       one-cycle pulse at end of burst
//   mem_en     ROM read enable (registered)
//   mem_addr   ROM address (registered, holds when mem_en=0)
//   mem_data   ROM read data, valid one cycle after mem_en
//   out_valid  stream word valid
//   out_ready  consumer accepts word
//   out_data   stream word, 0 when out_valid=0
//   out_last   marks the final word of the burst
//   out_parity XOR of out_data bits (only with ROM_BURST_READER_PARITY_EN)
//
// Optional feature macro: ROM_BURST_READER_PARITY_EN
module rom_burst_reader #(
    parameter int ADDR_W = 3,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   len,
    output logic              busy,
    output logic              done,
    output logic              mem_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last
`ifdef ROM_BURST_READER_PARITY_EN
    ,
    output logic              out_parity
`endif
);

    typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_FINISH} state_t;

    state_t            state_q;
    logic              busy_q;
    logic              done_q;
    logic              mem_en_q;
    logic              mem_last_q;   // read issued this cycle is the burst's last
    logic [ADDR_W-1:0] mem_addr_q;
    logic [ADDR_W:0]   rem_q;        // reads still to issue
    logic              pend_q;       // ROM data on mem_data this cycle
    logic              pend_last_q;

    // FIFO entries exposed as vectors; slot 3 is a constant empty entry that
    // shifts into slot 2 on a pop.
    logic [3:0]             ent_vld;
    logic [3:0]             ent_last;
    logic [3:0][DATA_W-1:0] ent_data;
`ifdef ROM_BURST_READER_PARITY_EN
    logic [3:0]             ent_par;
    assign ent_par[3] = 1'b0;
`endif
    assign ent_vld[3]  = 1'b0;
    assign ent_last[3] = 1'b0;
    assign ent_data[3] = '0;

    logic       pop;
    logic [1:0] fifo_cnt;
    logic [1:0] wr_idx;
    logic [2:0] occ;
    logic       credit_ok;

    assign pop      = ent_vld[0] & out_ready;
    assign fifo_cnt = 2'(ent_vld[0]) + 2'(ent_vld[1]) + 2'(ent_vld[2]);
    // Entries are kept contiguous from slot 0, so a push lands just past the
    // last valid entry after this cycle's pop has shifted the queue down.
    assign wr_idx   = fifo_cnt - 2'(pop);
    // Buffered + in-flight (issued last cycle, and data arriving now).
    assign occ       = 3'(fifo_cnt) + 3'(mem_en_q) + 3'(pend_q);
    assign credit_ok = occ < (3'd3 + 3'(pop));

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_fifo
            logic              vld_q;
            logic              last_q;
            logic [DATA_W-1:0] data_q;
`ifdef ROM_BURST_READER_PARITY_EN
            logic              par_q;
`endif
            always_ff @(posedge clk) begin
                if (rst) begin
                    vld_q  <= 1'b0;
                    last_q <= 1'b0;
                    data_q <= '0;
`ifdef ROM_BURST_READER_PARITY_EN
                    par_q  <= 1'b0;
`endif
                end else if (pend_q && (wr_idx == 2'(gi))) begin
                    vld_q  <= 1'b1;
                    last_q <= pend_last_q;
                    data_q <= mem_data;
`ifdef ROM_BURST_READER_PARITY_EN
                    par_q  <= ^mem_data;
`endif
                end else if (pop) begin
                    vld_q  <= ent_vld[gi+1];
                    last_q <= ent_last[gi+1];
                    data_q <= ent_data[gi+1];
`ifdef ROM_BURST_READER_PARITY_EN
                    par_q  <= ent_par[gi+1];
`endif
                end
            end
            assign ent_vld[gi]  = vld_q;
            assign ent_last[gi] = last_q;
            assign ent_data[gi] = data_q;
`ifdef ROM_BURST_READER_PARITY_EN
            assign ent_par[gi]  = par_q;
`endif
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_last_q  <= 1'b0;
            mem_addr_q  <= '0;
            rem_q       <= '0;
            pend_q      <= 1'b0;
            pend_last_q <= 1'b0;
        end else begin
            pend_q      <= mem_en_q;
            pend_last_q <= mem_last_q;
            done_q      <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_last_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        busy_q <= 1'b1;
                        if (len == '0) begin
                            state_q <= S_FINISH;
                            done_q  <= 1'b1;
                        end else begin
                            // First read goes out immediately; the FIFO is
                            // empty whenever we are idle.
                            mem_en_q   <= 1'b1;
                            mem_addr_q <= base_addr;
                            rem_q      <= len - (ADDR_W+1)'(1);
                            mem_last_q <= (len == (ADDR_W+1)'(1));
                            state_q    <= (len == (ADDR_W+1)'(1)) ? S_DRAIN : S_READ;
                        end
                    end
                end
                S_READ: begin
                    if (credit_ok) begin
                        mem_en_q   <= 1'b1;
                        mem_addr_q <= mem_addr_q + ADDR_W'(1);
                        rem_q      <= rem_q - (ADDR_W+1)'(1);
                        if (rem_q == (ADDR_W+1)'(1)) begin
                            mem_last_q <= 1'b1;
                            state_q    <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (pop && ent_last[0]) begin
                        state_q <= S_FINISH;
                        done_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign mem_en    = mem_en_q;
    assign mem_addr  = mem_addr_q;
    assign out_valid = ent_vld[0];
    assign out_data  = ent_data[0];
    assign out_last  = ent_last[0];
`ifdef ROM_BURST_READER_PARITY_EN
    assign out_parity = ent_par[0];
`endif

endmodule

// File: tb/tb_rom_burst_reader.sv
// Directed testbench for rom_burst_reader. A behavioural ROM returns
// mem[a] = a one cycle after mem_en. Cycle numbers count from the cycle in
// which start is sampled (cycle 0); outputs are sampled 1 time unit after
// each rising edge.
module tb_rom_burst_reader;
    localparam int AW = 3;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [AW:0]   len;
    logic          busy;
    logic          done;
    logic          mem_en;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_data = '0;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          out_last;
`ifdef ROM_BURST_READER_PARITY_EN
    logic          out_parity;
`endif

    int total = 0;
    int bad   = 0;

    rom_burst_reader #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_addr (base_addr),
        .len       (len),
        .busy      (busy),
        .done      (done),
        .mem_en    (mem_en),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last)
`ifdef ROM_BURST_READER_PARITY_EN
        ,
        .out_parity(out_parity)
`endif
    );

    always #5 clk = ~clk;

    // ROM model: mem[a] = a, registered read.
    always @(posedge clk) begin
        if (mem_en) mem_data <= {{(DW-AW){1'b0}}, mem_addr};
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; base_addr = '0; len = '0; out_ready = 1'b1;
        tick(); tick();
        rst = 1'b0;
        total++; if (busy !== 1'b0)      begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        total++; if (done !== 1'b0)      begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
        total++; if (mem_en !== 1'b0)    begin bad++; $display("FAIL reset_mem_en got=%b exp=0", mem_en); end
        total++; if (mem_addr !== 3'd0)  begin bad++; $display("FAIL reset_mem_addr got=%0d exp=0", mem_addr); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        total++; if (out_data !== 8'd0)  begin bad++; $display("FAIL reset_out_data got=%0d exp=0", out_data); end
        total++; if (out_last !== 1'b0)  begin bad++; $display("FAIL reset_out_last got=%b exp=0", out_last); end
        $display("reset: outputs checked");
    endtask

    // base 2, len 4, ready=1: exact cycle timing.
    task automatic test_basic();
        logic          e_busy, e_en, e_vld, e_last, e_done;
        logic [7:0]    e_data;
        logic [AW-1:0] e_addr;
        out_ready = 1'b1; base_addr = 3'd2; len = 4'd4; start = 1'b1;
        for (int c = 1; c <= 9; c++) begin
            tick();
            if (c == 1) start = 1'b0;
            e_busy = (c >= 1 && c <= 7);
            e_en   = (c >= 1 && c <= 4);
            e_vld  = (c >= 3 && c <= 6);
            e_last = (c == 6);
            e_done = (c == 7);
            e_data = e_vld ? 8'(c - 1) : 8'd0;
            e_addr = 3'(c + 1);
            total++; if (busy !== e_busy)      begin bad++; $display("FAIL basic_busy c=%0d got=%b exp=%b", c, busy, e_busy); end
            total++; if (mem_en !== e_en)      begin bad++; $display("FAIL basic_mem_en c=%0d got=%b exp=%b", c, mem_en, e_en); end
            total++; if (out_valid !== e_vld)  begin bad++; $display("FAIL basic_valid c=%0d got=%b exp=%b", c, out_valid, e_vld); end
            total++; if (out_last !== e_last)  begin bad++; $display("FAIL basic_last c=%0d got=%b exp=%b", c, out_last, e_last); end
            total++; if (done !== e_done)      begin bad++; $display("FAIL basic_done c=%0d got=%b exp=%b", c, done, e_done); end
            total++; if (out_data !== e_data)  begin bad++; $display("FAIL basic_data c=%0d got=%0d exp=%0d", c, out_data, e_data); end
            if (e_en) begin
                total++; if (mem_addr !== e_addr) begin bad++; $display("FAIL basic_addr c=%0d got=%0d exp=%0d", c, mem_addr, e_addr); end
            end
            if (out_valid && out_ready) $display("basic: cycle %0d word %0d last=%b", c, out_data, out_last);
        end
    endtask

    // base 6, len 5: address wraps 6,7,0,1,2.
    task automatic test_wrap();
        int exp_v[5] = '{6, 7, 0, 1, 2};
        int na = 0;
        int nw = 0;
        bit seen_done = 0;
        out_ready = 1'b1; base_addr = 3'd6; len = 4'd5; start = 1'b1;
        for (int c = 1; c <= 30; c++) begin
            tick();
            if (c == 1) start = 1'b0;
            if (mem_en) begin
                total++;
                if (na >= 5 || mem_addr !== 3'(exp_v[na])) begin
                    bad++; $display("FAIL wrap_addr idx=%0d got=%0d exp=%0d", na, mem_addr, (na < 5) ? exp_v[na] : -1);
                end
                na++;
            end
            if (out_valid && out_ready) begin
                total++;
                if (nw >= 5 || out_data !== 8'(exp_v[nw]) || out_last !== (nw == 4)) begin
                    bad++; $display("FAIL wrap_word idx=%0d got=%0d last=%b exp=%0d", nw, out_data, out_last, (nw < 5) ? exp_v[nw] : -1);
                end
                $display("wrap: word %0d last=%b", out_data, out_last);
                nw++;
            end
            if (done) begin seen_done = 1; break; end
        end
        total++; if (na != 5 || nw != 5 || !seen_done) begin
            bad++; $display("FAIL wrap_counts reads=%0d words=%0d done=%0d exp 5/5/1", na, nw, seen_done);
        end
    endtask

    // base 0, len 8, ready pattern 1,0,0,...
    task automatic test_backpressure();
        int issued = 0;
        int nw = 0;
        bit seen_done = 0;
        bit prev_stall = 0;
        logic [7:0] prev_data = '0;
        out_ready = 1'b1; base_addr = 3'd0; len = 4'd8; start = 1'b1;
        for (int c = 1; c <= 120; c++) begin
            tick();
            if (c == 1) start = 1'b0;
            out_ready = (c % 3 == 1);
            if (mem_en) issued++;
            total++; if (issued - nw > 3) begin bad++; $display("FAIL bp_credit c=%0d outstanding=%0d exp<=3", c, issued - nw); end
            if (prev_stall) begin
                total++; if (out_valid !== 1'b1 || out_data !== prev_data) begin
                    bad++; $display("FAIL bp_hold c=%0d got=%b/%0d exp=1/%0d", c, out_valid, out_data, prev_data);
                end
            end
            if (out_valid && out_ready) begin
                total++; if (out_data !== 8'(nw) || out_last !== (nw == 7)) begin
                    bad++; $display("FAIL bp_word idx=%0d got=%0d last=%b exp=%0d", nw, out_data, out_last, nw);
                end
                $display("bp: cycle %0d word %0d last=%b", c, out_data, out_last);
                nw++;
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            if (done) begin seen_done = 1; break; end
        end
        out_ready = 1'b1;
        total++; if (nw != 8 || issued != 8 || !seen_done) begin
            bad++; $display("FAIL bp_counts words=%0d reads=%0d done=%0d exp 8/8/1", nw, issued, seen_done);
        end
    endtask

    task automatic test_len0();
        out_ready = 1'b1; base_addr = 3'd5; len = 4'd0; start = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            tick();
            if (c == 1) start = 1'b0;
            total++; if (busy !== (c == 1))   begin bad++; $display("FAIL len0_busy c=%0d got=%b", c, busy); end
            total++; if (done !== (c == 1))   begin bad++; $display("FAIL len0_done c=%0d got=%b", c, done); end
            total++; if (mem_en !== 1'b0)     begin bad++; $display("FAIL len0_mem_en c=%0d got=%b exp=0", c, mem_en); end
            total++; if (out_valid !== 1'b0)  begin bad++; $display("FAIL len0_valid c=%0d got=%b exp=0", c, out_valid); end
        end
        $display("len0: checked");
    endtask

    // Ignored restart mid-burst, reset at cycle 4, then a fresh burst.
    task automatic test_abort();
        int nw = 0;
        bit seen_done = 0;
        out_ready = 1'b1; base_addr = 3'd0; len = 4'd6; start = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            tick();
            if (c <= 4) begin
                total++; if (mem_en !== 1'b1 || mem_addr !== 3'(c - 1)) begin
                    bad++; $display("FAIL abort_addr c=%0d got=%b/%0d exp=1/%0d", c, mem_en, mem_addr, c - 1);
                end
            end
            if (c == 3 || c == 4) begin
                total++; if (out_valid !== 1'b1 || out_data !== 8'(c - 3)) begin
                    bad++; $display("FAIL abort_word c=%0d got=%b/%0d exp=1/%0d", c, out_valid, out_data, c - 3);
                end
            end
            if (c == 5) begin
                total++; if ({busy, done, mem_en, mem_addr, out_valid, out_data, out_last} !== '0) begin
                    bad++; $display("FAIL abort_reset got busy=%b done=%b en=%b addr=%0d vld=%b data=%0d last=%b exp all 0",
                                    busy, done, mem_en, mem_addr, out_valid, out_data, out_last);
                end
                rst = 1'b0;
            end
            if (c >= 6) begin
                total++; if (done !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0) begin
                    bad++; $display("FAIL abort_quiet c=%0d done=%b vld=%b busy=%b exp 0", c, done, out_valid, busy);
                end
            end
            if (c == 1) start = 1'b0;
            if (c == 2) begin start = 1'b1; base_addr = 3'd5; len = 4'd3; end
            if (c == 3) start = 1'b0;
            if (c == 4) rst = 1'b1;
        end
        base_addr = 3'd1; len = 4'd2; start = 1'b1;
        for (int c = 1; c <= 15; c++) begin
            tick();
            if (c == 1) start = 1'b0;
            if (out_valid && out_ready) begin
                total++; if (out_data !== 8'(nw + 1) || out_last !== (nw == 1)) begin
                    bad++; $display("FAIL abort_new_word idx=%0d got=%0d last=%b exp=%0d", nw, out_data, out_last, nw + 1);
                end
                $display("abort: new burst word %0d last=%b", out_data, out_last);
                nw++;
            end
            if (done) begin seen_done = 1; break; end
        end
        total++; if (nw != 2 || !seen_done) begin
            bad++; $display("FAIL abort_new_counts words=%0d done=%0d exp 2/1", nw, seen_done);
        end
    endtask

`ifdef ROM_BURST_READER_PARITY_EN
    // Words 3..7 have parity 0,1,0,0,1.
    task automatic test_parity();
        logic exp_p[5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        int nw = 0;
        out_ready = 1'b1; base_addr = 3'd3; len = 4'd5; start = 1'b1;
        for (int c = 1; c <= 15; c++) begin
            tick();
            if (c == 1) start = 1'b0;
            if (!out_valid) begin
                total++; if (out_parity !== 1'b0) begin bad++; $display("FAIL parity_idle c=%0d got=%b exp=0", c, out_parity); end
            end else if (nw < 5) begin
                total++; if (out_parity !== exp_p[nw]) begin
                    bad++; $display("FAIL parity word=%0d got=%b exp=%b", out_data, out_parity, exp_p[nw]);
                end
                $display("parity: word %0d parity=%b", out_data, out_parity);
                nw++;
            end
            if (done) break;
        end
        total++; if (nw != 5) begin bad++; $display("FAIL parity_count got=%0d exp=5", nw); end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        tick(); tick();
        test_wrap();
        tick(); tick();
        test_backpressure();
        tick(); tick();
        test_len0();
        tick(); tick();
        test_abort();
        tick(); tick();
`ifdef ROM_BURST_READER_PARITY_EN
        test_parity();
        tick(); tick();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/rom_burst_reader.md
# rom_burst_reader

Read initiator for the synchronous 8x8 ROM interface (en/address in, registered data out one cycle later). On a start command it fetches a burst of consecutive words from a base address, wrapping at the top of the address space. It presents the words on a valid/ready output stream with full backpressure support. It sits between the ROM and any byte-stream consumer (UART TX, display driver).

## Interface
Parameters:
- ADDR_W, 3, ROM address width; address space is 2^ADDR_W words.
- DATA_W, 8, ROM data width.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  burst request; accepted only when busy=0.
- base_addr  in  ADDR_W  first address of the burst; sampled with start.
- len  in  ADDR_W+1  number of words to read (0..2^(ADDR_W+1)-1); sampled with start.
- busy  out  1  burst in progress.
- done  out  1  one-cycle pulse at end of burst.
- mem_en  out  1  ROM read enable (registered).
- mem_addr  out  ADDR_W  ROM address (registered).
- mem_data  in  DATA_W  ROM data; valid exactly 1 cycle after the mem_en cycle.
- out_valid  out  1  stream word valid.
- out_ready  in  1  consumer accepts word.
- out_data  out  DATA_W  stream word; 0 when out_valid=0.
- out_last  out  1  high with the final word of the burst.

## Operation
- Reset (synchronous, rst=1 at posedge): busy=0, done=0, mem_en=0, mem_addr=0, out_valid=0, out_data=0, out_last=0. FIFO is flushed and in-flight reads are discarded.
- States:
  - IDLE: start=1 latches base_addr/len and goes to READ (len>0) or FINISH (len=0).
  - READ: issue reads while credit permits; after len reads are issued go to DRAIN.
  - DRAIN: wait until the last word has been handshaken, then go to FINISH.
  - FINISH: done=1 for one cycle, then go to IDLE.
- Read k (k=0..len-1) uses address (base_addr + k) mod 2^ADDR_W. Wrap-around is silent. len > 2^ADDR_W re-reads addresses.
- Internal 3-entry FIFO captures mem_data on the cycle after each mem_en.
- Credit rule: issue a read only if (FIFO occupancy + reads in flight − pop this cycle) < 3. The FIFO never overflows, and no read is dropped.
- Handshake: a word transfers when out_valid & out_ready. out_data, out_last and out_valid hold stable while out_valid=1 and out_ready=0.
- out_last is asserted on word index len-1 only.
- start while busy=1 is ignored, with no effect on the burst in progress.
- When mem_en=0, mem_addr holds its last value.
- len=0: no mem_en, no out_valid; busy=1 for one cycle, with done in that same cycle.
- Reset mid-burst: the block returns to IDLE next cycle with no done pulse and no further stream words.

## Timing
- start sampled at cycle 0 with out_ready held at 1:
  - mem_en=1 in cycles 1..len, with consecutive addresses.
  - out_valid=1 in cycles 3..len+2, one word per cycle.
  - out_last=1 in cycle len+2.
  - done=1 in cycle len+3.
  - busy=1 in cycles 1..len+3.
- Latency from start to first word: 3 cycles. Sustained throughput: 1 word/cycle.
- With backpressure, reads stall so that at most 3 words are buffered or in flight. Reads resume in the same cycle a pop frees credit.
- done follows the last handshake by exactly 1 cycle.
- A new start is accepted in the cycle after done (earliest: cycle len+4).

## Configuration
- ROM_BURST_READER_PARITY_EN:
  - Defined: adds output port out_parity (1 bit), the even parity of out_data (XOR of all bits). It is registered alongside out_data, is 0 when out_valid=0, and follows the same hold-under-backpressure rule.
  - Undefined: the port and its logic are absent. All other behaviour is identical.

## Test plan
- ROM model mem[a]=a. Start with base_addr=2, len=4, out_ready=1 -> words 2,3,4,5 in cycles 3..6; out_last in cycle 6; done in cycle 7; busy cycles 1..7.
- base_addr=6, len=5 -> mem_addr sequence 6,7,0,1,2; words 6,7,0,1,2; out_last on the word value 2.
- base_addr=0, len=8, out_ready toggling 1,0,0,1,... -> all 8 words 0..7 in order, none lost or duplicated. Occupancy plus in-flight never exceeds 3. out_data stable while stalled.
- len=0 -> no mem_en, no out_valid; done pulse 1 cycle after start; busy=1 only in that cycle.
- start pulsed again mid-burst (len=6), then rst asserted at burst cycle 4 -> second start ignored. All outputs 0 the cycle after reset. No done. A later start with base_addr=1, len=2 yields words 1,2.
- With ROM_BURST_READER_PARITY_EN: words 0x03, 0x07 -> out_parity 0, 1.
